bcd_counter_sevenseg_mux: RTL and testbench

//  Parametrised N-digit BCD up/down counter with time-multiplexed 7-segment drive.

---
 rtl/bcd_counter_sevenseg_mux.sv | 185 ++++++++++++++++++
 tb/tb_bcd_counter_sevenseg_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_sevenseg_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_counter_sevenseg_mux                                     |
// | Description : N-digit BCD up/down counter, prescaled tick, time-muxed      |
// |               7-segment drive. Optional: LEADING_ZERO_BLANK_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_counter_sevenseg_mux #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 12000000,
  parameter int SCAN_DIV       = 12000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] c_presc_last = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] c_scan_last  = TW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_idx_last   = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    SCAN_HOLD    = 1'b0,
    SCAN_ADVANCE = 1'b1
  } scan_state_t;

  // With a one-cycle dwell the timer sits on its last value permanently.
  localparam scan_state_t c_scan_rst = (SCAN_DIV == 1) ? SCAN_ADVANCE : SCAN_HOLD;

  logic [PW-1:0]        presc_q, presc_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 wrap_q, wrap_d;
  scan_state_t          scan_state_q, scan_state_d;
  logic [TW-1:0]        scan_timer_q, scan_timer_d;
  logic [IW-1:0]        scan_idx_q, scan_idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    dig_sel_q, dig_sel_d;

  logic                 tick;
  logic                 step_carry;
  logic [4*DIGITS-1:0]  load_clean;
  logic [4*DIGITS-1:0]  bcd_step;
  logic [DIGITS-1:0]    blank;
  logic                 zero_run;
  logic                 blank_sel;
  logic [3:0]           digit_nib;

  // Ripple carry/borrow through the digits; the final carry is the wrap condition.
  always_comb begin
    tick       = en && (presc_q == c_presc_last);
    load_clean = load_val;
    bcd_step   = bcd_q;
    step_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
      end
      if (step_carry) begin
        if (up) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = 4'd9;
          end else begin
            bcd_step[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end

    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    if (load) begin
      bcd_d   = load_clean;
      presc_d = '0;
    end else if (en) begin
      if (tick) begin
        presc_d = '0;
        bcd_d   = bcd_step;
        wrap_d  = step_carry;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // ADVANCE is entered exactly when the timer reaches its last value.
  always_comb begin
    scan_timer_d = scan_timer_q + TW'(1);
    scan_idx_d   = scan_idx_q;
    if (scan_state_q == SCAN_ADVANCE) begin
      scan_timer_d = '0;
      scan_idx_d   = (scan_idx_q == c_idx_last) ? '0 : scan_idx_q + IW'(1);
    end
    scan_state_d = (scan_timer_d == c_scan_last) ? SCAN_ADVANCE : SCAN_HOLD;
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
`endif
  end

  always_comb begin
    digit_nib = 4'd0;
    blank_sel = 1'b0;
    dig_sel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        digit_nib    = bcd_q[4*i +: 4];
        blank_sel    = blank[i];
        dig_sel_d[i] = 1'b1;
      end
    end
    case (digit_nib)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h00;
    endcase
    if (blank_sel) begin
      seg_d = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      bcd_q        <= '0;
      wrap_q       <= 1'b0;
      scan_state_q <= c_scan_rst;
      scan_timer_q <= '0;
      scan_idx_q   <= '0;
      seg_q        <= 7'h00;
      dig_sel_q    <= '0;
    end else begin
      presc_q      <= presc_d;
      bcd_q        <= bcd_d;
      wrap_q       <= wrap_d;
      scan_state_q <= scan_state_d;
      scan_timer_q <= scan_timer_d;
      scan_idx_q   <= scan_idx_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign bcd     = bcd_q;
  assign wrap    = wrap_q;
  assign seg     = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dig_sel = dig_sel_q ^ {DIGITS{SEG_ACTIVE_LOW}};

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_sevenseg_mux.sv
`default_nettype none
// Testbench for bcd_counter_sevenseg_mux: scoreboard of expected count/display values,
// one active-high and one active-low instance sharing the same stimulus.
module tb_bcd_counter_sevenseg_mux;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] bcd, bcd_n;
  logic        wrap, wrap_n;
  logic [6:0]  seg, seg_n;
  logic [3:0]  dig_sel, dig_sel_n;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
  } cnt_exp_t;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
  } disp_exp_t;

  cnt_exp_t  cnt_q[$];
  disp_exp_t disp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] c_lz = 7'h00;
`else
  localparam logic [6:0] c_lz = 7'h3F;
`endif

  always #5 clk = ~clk;

  bcd_counter_sevenseg_mux #(
    .DIGITS(4), .PRESCALE(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .bcd(bcd), .wrap(wrap), .seg(seg), .dig_sel(dig_sel)
  );

  bcd_counter_sevenseg_mux #(
    .DIGITS(4), .PRESCALE(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .bcd(bcd_n), .wrap(wrap_n), .seg(seg_n), .dig_sel(dig_sel_n)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    cnt_exp_t  ce;
    disp_exp_t de;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    cnt_q.push_back(cnt_exp_t'{16'h0000, 1'b0});
    disp_q.push_back(disp_exp_t'{7'h00, 4'b0000, 7'h7F, 4'b1111});
    cyc(2);
    ce = cnt_q.pop_front();
    de = disp_q.pop_front();
    n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL reset_bcd: got %h expected %h", bcd, ce.bcd); end
    n_checks++; if (wrap !== ce.wrap) begin n_fail++; $display("FAIL reset_wrap: got %b expected %b", wrap, ce.wrap); end
    n_checks++; if (seg !== de.seg) begin n_fail++; $display("FAIL reset_seg: got %h expected %h", seg, de.seg); end
    n_checks++; if (dig_sel !== de.dig) begin n_fail++; $display("FAIL reset_dig: got %b expected %b", dig_sel, de.dig); end
    n_checks++; if (seg_n !== de.seg_n) begin n_fail++; $display("FAIL reset_seg_n: got %h expected %h", seg_n, de.seg_n); end
    n_checks++; if (dig_sel_n !== de.dig_n) begin n_fail++; $display("FAIL reset_dig_n: got %b expected %b", dig_sel_n, de.dig_n); end
    rst = 1'b0;
    disp_q.push_back(disp_exp_t'{7'h3F, 4'b0001, 7'h40, 4'b1110});
    cyc(1);
    de = disp_q.pop_front();
    n_checks++; if (dig_sel !== de.dig) begin n_fail++; $display("FAIL release_dig: got %b expected %b", dig_sel, de.dig); end
    n_checks++; if (seg !== de.seg) begin n_fail++; $display("FAIL release_seg: got %h expected %h", seg, de.seg); end
  endtask

  task automatic test_carry();
    cnt_exp_t ce;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0998;
    cyc(1);
    load = 1'b0;
    cnt_q.push_back(cnt_exp_t'{16'h0999, 1'b0});
    cnt_q.push_back(cnt_exp_t'{16'h1000, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL carry_wrap k=%0d: got %b expected 0", k, wrap); end
      if (k == 4 || k == 8) begin
        ce = cnt_q.pop_front();
        n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL carry_bcd k=%0d: got %h expected %h", k, bcd, ce.bcd); end
      end
    end
  endtask

  task automatic test_wrap();
    cnt_exp_t ce;
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9999;
    cyc(1);
    load = 1'b0;
    cnt_q.push_back(cnt_exp_t'{16'h0000, 1'b1});
    cnt_q.push_back(cnt_exp_t'{16'h0000, 1'b0});
    cyc(4);
    for (int k = 0; k < 2; k++) begin
      ce = cnt_q.pop_front();
      n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL wrap_up_bcd k=%0d: got %h expected %h", k, bcd, ce.bcd); end
      n_checks++; if (wrap !== ce.wrap) begin n_fail++; $display("FAIL wrap_up_pulse k=%0d: got %b expected %b", k, wrap, ce.wrap); end
      if (k == 0) cyc(1);
    end
    up = 1'b0;
    cnt_q.push_back(cnt_exp_t'{16'h9999, 1'b1});
    cnt_q.push_back(cnt_exp_t'{16'h9999, 1'b0});
    cyc(3);
    for (int k = 0; k < 2; k++) begin
      ce = cnt_q.pop_front();
      n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL wrap_dn_bcd k=%0d: got %h expected %h", k, bcd, ce.bcd); end
      n_checks++; if (wrap !== ce.wrap) begin n_fail++; $display("FAIL wrap_dn_pulse k=%0d: got %b expected %b", k, wrap, ce.wrap); end
      if (k == 0) cyc(1);
    end
    // Prescaler is at 1 here; two more edges bring it to the tick value.
    up = 1'b1;
    cyc(2);
    load = 1'b1; load_val = 16'h5555;
    cnt_q.push_back(cnt_exp_t'{16'h5555, 1'b0});
    cnt_q.push_back(cnt_exp_t'{16'h5555, 1'b0});
    cyc(1);
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ce = cnt_q.pop_front();
      n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL load_tick_bcd k=%0d: got %h expected %h", k, bcd, ce.bcd); end
      n_checks++; if (wrap !== ce.wrap) begin n_fail++; $display("FAIL load_tick_wrap k=%0d: got %b expected %b", k, wrap, ce.wrap); end
      if (k == 0) cyc(1);
    end
  endtask

  task automatic test_load_hold();
    cnt_exp_t ce;
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 16'h00A5;
    cnt_q.push_back(cnt_exp_t'{16'h0005, 1'b0});
    cyc(1);
    ce = cnt_q.pop_front();
    n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL load_00A5: got %h expected %h", bcd, ce.bcd); end
    load_val = 16'hC3B7;
    cnt_q.push_back(cnt_exp_t'{16'h0307, 1'b0});
    cyc(1);
    ce = cnt_q.pop_front();
    n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL load_C3B7: got %h expected %h", bcd, ce.bcd); end
    load = 1'b0; en = 1'b1;
    cyc(2);
    en = 1'b0;
    cnt_q.push_back(cnt_exp_t'{16'h0307, 1'b0});
    cyc(20);
    ce = cnt_q.pop_front();
    n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL hold_bcd: got %h expected %h", bcd, ce.bcd); end
    en = 1'b1;
    cnt_q.push_back(cnt_exp_t'{16'h0307, 1'b0});
    cnt_q.push_back(cnt_exp_t'{16'h0308, 1'b0});
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      ce = cnt_q.pop_front();
      n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL resume_bcd k=%0d: got %h expected %h", k, bcd, ce.bcd); end
    end
  endtask

  // Reset, then load pattern on the release cycle so the scan phase is known.
  task automatic scan_pattern(input logic [15:0] pat, input logic [6:0] exp_seg [4], input string tag);
    disp_exp_t  de;
    logic [3:0] one;
    int         idx;
    one = 4'b0001;
    en = 1'b0; load = 1'b0; rst = 1'b1;
    cyc(1);
    rst = 1'b0; load = 1'b1; load_val = pat;
    for (int k = 2; k <= 17; k++) begin
      idx = ((k - 1) / 2) % 4;
      disp_q.push_back(disp_exp_t'{exp_seg[idx], one << idx, ~exp_seg[idx], ~(one << idx)});
    end
    cyc(1);
    load = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      cyc(1);
      de = disp_q.pop_front();
      n_checks++; if (seg !== de.seg) begin n_fail++; $display("FAIL %s_seg k=%0d: got %h expected %h", tag, k, seg, de.seg); end
      n_checks++; if (dig_sel !== de.dig) begin n_fail++; $display("FAIL %s_dig k=%0d: got %b expected %b", tag, k, dig_sel, de.dig); end
      n_checks++; if (seg_n !== de.seg_n) begin n_fail++; $display("FAIL %s_seg_n k=%0d: got %h expected %h", tag, k, seg_n, de.seg_n); end
      n_checks++; if (dig_sel_n !== de.dig_n) begin n_fail++; $display("FAIL %s_dig_n k=%0d: got %b expected %b", tag, k, dig_sel_n, de.dig_n); end
    end
  endtask

  task automatic test_scan();
    logic [6:0] t1234 [4];
    t1234 = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    scan_pattern(16'h1234, t1234, "scan1234");
  endtask

  task automatic test_blank_and_reset();
    logic [6:0] t0007 [4];
    logic [6:0] t1007 [4];
    cnt_exp_t   ce;
    disp_exp_t  de;
    t0007 = '{7'h07, c_lz, c_lz, c_lz};
    t1007 = '{7'h07, 7'h3F, 7'h3F, 7'h06};
    scan_pattern(16'h0007, t0007, "lz0007");
    scan_pattern(16'h1007, t1007, "lz1007");
    rst = 1'b1;
    cnt_q.push_back(cnt_exp_t'{16'h0000, 1'b0});
    disp_q.push_back(disp_exp_t'{7'h00, 4'b0000, 7'h7F, 4'b1111});
    cyc(1);
    ce = cnt_q.pop_front();
    de = disp_q.pop_front();
    n_checks++; if (bcd !== ce.bcd) begin n_fail++; $display("FAIL midrst_bcd: got %h expected %h", bcd, ce.bcd); end
    n_checks++; if (wrap !== ce.wrap) begin n_fail++; $display("FAIL midrst_wrap: got %b expected %b", wrap, ce.wrap); end
    n_checks++; if (seg !== de.seg) begin n_fail++; $display("FAIL midrst_seg: got %h expected %h", seg, de.seg); end
    n_checks++; if (dig_sel !== de.dig) begin n_fail++; $display("FAIL midrst_dig: got %b expected %b", dig_sel, de.dig); end
    n_checks++; if (seg_n !== de.seg_n) begin n_fail++; $display("FAIL midrst_seg_n: got %h expected %h", seg_n, de.seg_n); end
    n_checks++; if (dig_sel_n !== de.dig_n) begin n_fail++; $display("FAIL midrst_dig_n: got %b expected %b", dig_sel_n, de.dig_n); end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_carry();
    test_wrap();
    test_load_hold();
    test_scan();
    test_blank_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
